// File: rtl/adc_ramp_sequencer.sv
// adc_ramp_sequencer
//   Conversion controller for a PWM-DAC ramp ADC. For every channel selected
//   in the latched mask it switches the analog mux, waits for the front end to
//   settle, then ramps the PWM duty code upward one step at a time until the
//   synchronized comparator trips (or the top code is reached). Each result is
//   delivered as a tagged, left-justified 16-bit sample with a one-cycle
//   data_ready pulse.
//
// Ports
//   clk          system clock
//   reset        asynchronous, active-high reset
//   enable       block enable; low aborts the round on the next edge
//   start        one-cycle request to begin a conversion round (IDLE only)
//   continuous   when high, a finished round relatches ch_mask and restarts
//   ch_mask      channels included in a round
//   comparator   asynchronous comparator, 1 = ramp voltage above input
//   duty_cycle   PWM duty code driven to the PWM generator
//   mux_sel      analog mux channel select
//   busy         high whenever the sequencer is not idle
//   data_ready   one-cycle pulse marking a new sample
//   data_ch      channel of the current sample
//   adc_out      code << (12-WIDTH), upper four bits zero
//   overrange    sample reached the top code without a trip
module adc_ramp_sequencer #(
  parameter int WIDTH         = 8,
  parameter int NUM_CH        = 4,
  parameter int STEP_CYCLES   = 196,
  parameter int SETTLE_CYCLES = 1000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      start,
  input  logic                      continuous,
  input  logic [NUM_CH-1:0]         ch_mask,
  input  logic                      comparator,
  output logic [WIDTH-1:0]          duty_cycle,
  output logic [$clog2(NUM_CH)-1:0] mux_sel,
  output logic                      busy,
  output logic                      data_ready,
  output logic [$clog2(NUM_CH)-1:0] data_ch,
  output logic [15:0]               adc_out,
  output logic                      overrange
);

  localparam int CH_W    = $clog2(NUM_CH);
  localparam int CNT_MAX = (STEP_CYCLES > SETTLE_CYCLES) ? STEP_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam int SHIFT   = 12 - WIDTH;

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STEP_LAST   = CNT_W'(STEP_CYCLES - 1);
  localparam logic [WIDTH-1:0] MAX_CODE    = {WIDTH{1'b1}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    RAMP   = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Lowest set bit of mask at index >= from; result is {found, index}.
  // Scanning downward lets the last hit (the lowest index) win without a break.
  function automatic logic [CH_W:0] next_ch(input logic [NUM_CH-1:0] mask, input int from);
    logic            found;
    logic [CH_W-1:0] idx;
    logic            hit;
    found = 1'b0;
    idx   = {CH_W{1'b0}};
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      hit   = mask[i] && (i >= from);
      found = found | hit;
      idx   = hit ? CH_W'(i) : idx;
    end
    return {found, idx};
  endfunction

  state_t             state_q,      state_d;
  logic [NUM_CH-1:0]  mask_q,       mask_d;
  logic [CH_W-1:0]    ch_q,         ch_d;
  logic [WIDTH-1:0]   duty_q,       duty_d;
  logic [CNT_W-1:0]   cnt_q,        cnt_d;
  logic [WIDTH-1:0]   code_q,       code_d;
  logic               ovr_q,        ovr_d;
  logic               busy_q,       busy_d;
  logic               data_ready_q, data_ready_d;
  logic [CH_W-1:0]    data_ch_q,    data_ch_d;
  logic [15:0]        adc_out_q,    adc_out_d;
  logic               overrange_q,  overrange_d;
  logic               comp_meta_q,  comp_sync_q;

  logic [CH_W:0]      first_s;
  logic [CH_W:0]      nxt_in_round_s;

  assign first_s        = next_ch(ch_mask, 0);
  assign nxt_in_round_s = next_ch(mask_q, int'(ch_q) + 1);

  // Two-flop synchronizer for the asynchronous comparator.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      comp_meta_q <= 1'b0;
      comp_sync_q <= 1'b0;
    end else begin
      comp_meta_q <= comparator;
      comp_sync_q <= comp_meta_q;
    end
  end

  // Next-state and output computation for the conversion sequencer.
  always_comb begin
    state_d      = state_q;
    mask_d       = mask_q;
    ch_d         = ch_q;
    duty_d       = duty_q;
    cnt_d        = cnt_q;
    code_d       = code_q;
    ovr_d        = ovr_q;
    data_ready_d = 1'b0;
    data_ch_d    = data_ch_q;
    adc_out_d    = adc_out_q;
    overrange_d  = overrange_q;

    if (!enable) begin
      // Abort: the round is dropped and sample outputs keep their values.
      state_d = IDLE;
      duty_d  = {WIDTH{1'b0}};
      cnt_d   = {CNT_W{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          if (start && first_s[CH_W]) begin
            mask_d  = ch_mask;
            ch_d    = first_s[CH_W-1:0];
            duty_d  = {WIDTH{1'b0}};
            cnt_d   = {CNT_W{1'b0}};
            state_d = SELECT;
          end else begin
            state_d = IDLE;
          end
        end
        SELECT: begin
          if (cnt_q == SETTLE_LAST) begin
            cnt_d   = {CNT_W{1'b0}};
            state_d = RAMP;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        RAMP: begin
          if (cnt_q == STEP_LAST) begin
            cnt_d = {CNT_W{1'b0}};
            if (comp_sync_q) begin
              code_d  = duty_q;
              ovr_d   = 1'b0;
              duty_d  = {WIDTH{1'b0}};
              state_d = DONE;
            end else if (duty_q == MAX_CODE) begin
              code_d  = MAX_CODE;
              ovr_d   = 1'b1;
              duty_d  = {WIDTH{1'b0}};
              state_d = DONE;
            end else begin
              duty_d = duty_q + WIDTH'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          data_ready_d = 1'b1;
          adc_out_d    = 16'(code_q) << SHIFT;
          data_ch_d    = ch_q;
          overrange_d  = ovr_q;
          cnt_d        = {CNT_W{1'b0}};
          if (nxt_in_round_s[CH_W]) begin
            ch_d    = nxt_in_round_s[CH_W-1:0];
            state_d = SELECT;
          end else if (continuous) begin
            mask_d = ch_mask;
            if (first_s[CH_W]) begin
              ch_d    = first_s[CH_W-1:0];
              state_d = SELECT;
            end else begin
              state_d = IDLE;
            end
          end else begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          duty_d  = {WIDTH{1'b0}};
          cnt_d   = {CNT_W{1'b0}};
        end
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      mask_q       <= {NUM_CH{1'b0}};
      ch_q         <= {CH_W{1'b0}};
      duty_q       <= {WIDTH{1'b0}};
      cnt_q        <= {CNT_W{1'b0}};
      code_q       <= {WIDTH{1'b0}};
      ovr_q        <= 1'b0;
      busy_q       <= 1'b0;
      data_ready_q <= 1'b0;
      data_ch_q    <= {CH_W{1'b0}};
      adc_out_q    <= 16'h0000;
      overrange_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      mask_q       <= mask_d;
      ch_q         <= ch_d;
      duty_q       <= duty_d;
      cnt_q        <= cnt_d;
      code_q       <= code_d;
      ovr_q        <= ovr_d;
      busy_q       <= busy_d;
      data_ready_q <= data_ready_d;
      data_ch_q    <= data_ch_d;
      adc_out_q    <= adc_out_d;
      overrange_q  <= overrange_d;
    end
  end

  assign duty_cycle = duty_q;
  assign mux_sel    = ch_q;
  assign busy       = busy_q;
  assign data_ready = data_ready_q;
  assign data_ch    = data_ch_q;
  assign adc_out    = adc_out_q;
  assign overrange  = overrange_q;

endmodule

// File: tb/tb_adc_ramp_sequencer.sv
// Testbench for adc_ramp_sequencer with short settle/step times.
// The analog front end is modelled per channel as a trip threshold: the
// comparator reads 1 once duty_cycle >= thr[mux_sel] (256 = never trips).
// Expected samples and their pulse cycles are queued when a round is started;
// a monitor pops and compares on every data_ready.
module tb_adc_ramp_sequencer;
  localparam int W      = 8;
  localparam int NCH    = 4;
  localparam int STEP   = 4;
  localparam int SETTLE = 6;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic         start;
  logic         continuous;
  logic [3:0]   ch_mask;
  logic         comparator;
  logic [W-1:0] duty_cycle;
  logic [1:0]   mux_sel;
  logic         busy;
  logic         data_ready;
  logic [1:0]   data_ch;
  logic [15:0]  adc_out;
  logic         overrange;

  adc_ramp_sequencer #(
    .WIDTH(W), .NUM_CH(NCH), .STEP_CYCLES(STEP), .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .start(start),
    .continuous(continuous), .ch_mask(ch_mask), .comparator(comparator),
    .duty_cycle(duty_cycle), .mux_sel(mux_sel), .busy(busy),
    .data_ready(data_ready), .data_ch(data_ch), .adc_out(adc_out),
    .overrange(overrange)
  );

  always #5 clk = ~clk;

  int   thr [NCH];
  logic glitch;
  assign comparator = glitch | (int'(duty_cycle) >= thr[mux_sel]);

  typedef struct {
    int     ch;
    int     adc;
    int     ovr;
    longint t;
  } exp_t;

  exp_t   sb_q[$];
  exp_t   mon_e;
  int     n_chk = 0;
  int     n_pass = 0;
  longint cyc = 0;
  longint acc_t = 0;
  int     last_adc = 0;
  int     step_err = 0;
  logic [W-1:0] prev_duty = '0;
  bit     watch_busy = 1'b0;
  longint watch_end = 0;
  int     busy_low = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!reset && data_ready) begin
      chk("pulse_expected", longint'(sb_q.size() > 0), 1);
      if (sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        chk("data_ch", data_ch, mon_e.ch);
        chk("adc_out", adc_out, mon_e.adc);
        chk("overrange", overrange, mon_e.ovr);
        chk("pulse_cycle", cyc, mon_e.t);
        last_adc = mon_e.adc;
      end
    end
  end

  // Duty code may only hold, step up by one, or return to zero
  always @(negedge clk) begin
    if (!reset && duty_cycle != prev_duty && duty_cycle != 8'd0 &&
        duty_cycle != prev_duty + 8'd1) step_err++;
    prev_duty = duty_cycle;
  end

  // Busy watcher for continuous mode
  always @(negedge clk) begin
    if (watch_busy && cyc < watch_end && !busy) busy_low++;
  end

  // Reference model: ascending channel order, each channel's result arrives
  // settle + (code+1) steps + 1 cycles after the previous accept/pulse edge.
  task automatic model_round(input logic [3:0] m, input longint t0, output longint t_end);
    longint t;
    int     code;
    exp_t   e;
    t = t0;
    for (int c = 0; c < NCH; c++) begin
      if (m[c]) begin
        code  = (thr[c] > 255) ? 255 : thr[c];
        t     = t + SETTLE + (code + 1) * STEP + 1;
        e.ch  = c;
        e.adc = code * (1 << (12 - W));
        e.ovr = (thr[c] > 255) ? 1 : 0;
        e.t   = t;
        sb_q.push_back(e);
      end
    end
    t_end = t;
  endtask

  task automatic go(input logic [3:0] m);
    @(negedge clk);
    ch_mask = m;
    start   = 1'b1;
    acc_t   = cyc + 1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic drain(input int budget, input bit nuisance, input string name);
    int n;
    n = 0;
    while ((sb_q.size() != 0 || busy) && n < budget) begin
      if (nuisance) begin
        start   = busy && ($urandom_range(0, 7) == 0);
        ch_mask = 4'($urandom);
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk({name, "_done_in_time"}, longint'(n < budget), 1);
  endtask

  task automatic wait_duty(input int v, input string name);
    int n;
    n = 0;
    while (int'(duty_cycle) != v && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_reached"}, longint'(n < 5000), 1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    longint tl, t1, t2, t3, tmid;
    int     n;
    logic [W-1:0] prevd;
    logic [3:0]   m;

    reset = 1'b1; enable = 1'b0; start = 1'b0; continuous = 1'b0;
    ch_mask = 4'd0; glitch = 1'b0;
    for (int i = 0; i < NCH; i++) thr[i] = 256;
    repeat (3) @(negedge clk);
    chk("rst_duty", duty_cycle, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data_ready", data_ready, 0);
    chk("rst_adc_out", adc_out, 0);
    chk("rst_overrange", overrange, 0);
    chk("rst_mux_sel", mux_sel, 0);
    chk("rst_data_ch", data_ch, 0);
    reset = 1'b0;
    enable = 1'b1;
    @(negedge clk);

    // Single channel, trip at code 100 -> 0x640
    thr[0] = 100;
    go(4'b0001);
    model_round(4'b0001, acc_t, tl);
    drain(2000, 1'b0, "single");

    // Overrange on channel 2
    for (int i = 0; i < NCH; i++) thr[i] = 256;
    go(4'b0100);
    model_round(4'b0100, acc_t, tl);
    drain(2000, 1'b0, "overrange");

    // Multi-channel order with start/mask noise during the round
    thr[1] = 0; thr[3] = 37;
    go(4'b1010);
    model_round(4'b1010, acc_t, tl);
    drain(2000, 1'b1, "multi");

    // Randomized rounds
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < NCH; i++)
        thr[i] = ($urandom_range(0, 7) == 0) ? 256 : int'($urandom_range(0, 40));
      m = 4'($urandom_range(1, 15));
      go(m);
      model_round(m, acc_t, tl);
      drain(5000, 1'b1, "random");
    end

    // Continuous: three rounds, mask cleared during the third
    thr[0] = 5; thr[1] = 9;
    continuous = 1'b1;
    busy_low = 0;
    go(4'b0011);
    model_round(4'b0011, acc_t, t1);
    model_round(4'b0011, t1, t2);
    model_round(4'b0011, t2, t3);
    tmid = t2 + SETTLE + (thr[0] + 1) * STEP + 1;
    watch_end = t3;
    watch_busy = 1'b1;
    n = 0;
    while (cyc < tmid + 2 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("cont_mid_reached", longint'(n < 2000), 1);
    ch_mask = 4'b0000;
    drain(2000, 1'b0, "cont");
    watch_busy = 1'b0;
    chk("cont_busy_never_dropped", busy_low, 0);
    continuous = 1'b0;
    repeat (10) @(negedge clk);
    chk("cont_idle_after_mask0", busy, 0);

    // Abort by enable mid-ramp
    thr[2] = 200;
    go(4'b0100);
    model_round(4'b0100, acc_t, tl);
    wait_duty(50, "abort_duty");
    enable = 1'b0;
    @(negedge clk);
    chk("abort_duty", duty_cycle, 0);
    chk("abort_busy", busy, 0);
    chk("abort_adc_hold", adc_out, last_adc);
    sb_q.delete();
    repeat (5) @(negedge clk);
    enable = 1'b1;
    thr[2] = 20;
    go(4'b0100);
    model_round(4'b0100, acc_t, tl);
    drain(2000, 1'b0, "after_abort");

    // Reset mid-ramp on channel 1
    thr[1] = 150;
    go(4'b0010);
    model_round(4'b0010, acc_t, tl);
    wait_duty(30, "reset_duty");
    #1 reset = 1'b1;
    #1;
    chk("midrst_duty", duty_cycle, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_adc_out", adc_out, 0);
    chk("midrst_mux_sel", mux_sel, 0);
    sb_q.delete();
    @(negedge clk);
    reset = 1'b0;
    last_adc = 0;
    thr[1] = 12;
    go(4'b0010);
    model_round(4'b0010, acc_t, tl);
    drain(2000, 1'b0, "after_reset");

    // Start with empty mask is ignored
    go(4'b0000);
    repeat (4) @(negedge clk);
    chk("mask0_busy", busy, 0);

    // One-cycle comparator glitches right after each code change never trip
    for (int i = 0; i < NCH; i++) thr[i] = 256;
    go(4'b0010);
    model_round(4'b0010, acc_t, tl);
    prevd = duty_cycle;
    n = 0;
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
      if (duty_cycle != prevd && duty_cycle != 8'd0) begin
        glitch = 1'b1;
        @(negedge clk);
        glitch = 1'b0;
        n++;
      end
      prevd = duty_cycle;
    end
    drain(2000, 1'b0, "glitch");

    repeat (5) @(negedge clk);
    chk("duty_steps", step_err, 0);
    chk("sb_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
